// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state type for the SPI master
package spi_pkg;

  localparam int   SPI_DATA_W = 8;
  localparam int   SPI_BITS   = 8;
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - core-side byte handshake between the local core and the SPI master
interface spi_master_if;
  import spi_pkg::*;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_DATA_W-1:0] tx_data;
  logic                  rx_valid;
  logic [SPI_DATA_W-1:0] rx_data;
  logic                  busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, busy
  );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter: counts 0..DIV-1, ticks on terminal count
module spi_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Wrapping on the tick also restarts the count for whatever state comes next.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-1 MSB-first 8-bit SPI master with active-low chip select
// Optional feature: SPI_MASTER_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  bus,
  output logic         sclk,
  output logic         cs,
  output logic         mosi,
  input  logic         miso
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic         loopback
`endif
);

  spi_state_t            state_q;
  logic [SPI_DATA_W-1:0] shift_q;
  logic [SPI_DATA_W-1:0] rx_sh_q;
  logic [SPI_DATA_W-1:0] rx_data_q;
  logic [3:0]            bit_cnt_q;
  logic                  sclk_q;
  logic                  cs_q;
  logic                  mosi_q;
  logic                  rx_valid_q;
  logic                  busy_q;
  logic                  tx_ready_q;
  logic                  tick;
  logic                  sample_bit;

  spi_clk_div #(.DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  assign sample_bit = lb_q ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  assign sclk         = sclk_q;
  assign cs           = cs_q;
  assign mosi         = mosi_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= SPI_CPOL;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.tx_valid && tx_ready_q) begin
            shift_q    <= bus.tx_data;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q       <= loopback;
`endif
          end
        end
        SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            mosi_q  <= shift_q[SPI_DATA_W-1];
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // The low half-period after the last falling edge still belongs to SHIFT.
          if (tick) begin
            if (sclk_q) begin
              sclk_q    <= 1'b0;
              rx_sh_q   <= {rx_sh_q[SPI_DATA_W-2:0], sample_bit};
              shift_q   <= {shift_q[SPI_DATA_W-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'(SPI_BITS)) begin
              mosi_q  <= 1'b0;
              state_q <= HOLD;
            end else begin
              sclk_q <= 1'b1;
              mosi_q <= shift_q[SPI_DATA_W-1];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_q       <= 1'b1;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            state_q    <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at CLK_DIV 2 (dut 0) and CLK_DIV 1 (dut 1)
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  spi_master_if bus0();
  spi_master_if bus1();

  logic [1:0] sclk_w, cs_w, mosi_w, miso_w;
  logic [1:0] txv = '0;
  logic [1:0] rdy, rxv, bsy;
  logic [7:0] txd [2];
  logic [7:0] rxd [2];
  logic [1:0] miso_s = '0;
  logic       tie0 = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic [1:0] lb = '0;
`endif

  assign miso_w = tie0 ? 2'b00 : miso_s;

  assign bus0.tx_valid = txv[0];
  assign bus0.tx_data  = txd[0];
  assign bus1.tx_valid = txv[1];
  assign bus1.tx_data  = txd[1];
  assign rdy[0] = bus0.tx_ready;
  assign rdy[1] = bus1.tx_ready;
  assign rxv[0] = bus0.rx_valid;
  assign rxv[1] = bus1.rx_valid;
  assign bsy[0] = bus0.busy;
  assign bsy[1] = bus1.busy;
  assign rxd[0] = bus0.rx_data;
  assign rxd[1] = bus1.rx_data;

  spi_master #(.CLK_DIV(2)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0),
    .sclk  (sclk_w[0]),
    .cs    (cs_w[0]),
    .mosi  (mosi_w[0]),
    .miso  (miso_w[0])
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .loopback (lb[0])
`endif
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1),
    .sclk  (sclk_w[1]),
    .cs    (cs_w[1]),
    .mosi  (mosi_w[1]),
    .miso  (miso_w[1])
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .loopback (lb[1])
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Frames never overlap across the two DUTs, so shared queues keep order.
  logic [7:0] pre_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] sl_q[$];
  bit abort = 1'b0;

  logic [7:0] slv_tx [2];
  logic [7:0] slv_rx [2];
  logic [7:0] slv_rise [2];
  logic [1:0] sclk_p = '0;
  logic [1:0] cs_p = 2'b11;
  logic [1:0] rxv_p = '0;
  int cs_lo [2] = '{default: 0};
  int cs_hi [2] = '{default: 0};
  int tog [2] = '{default: 0};
  int first_tog [2] = '{default: 0};
  int last_tog [2] = '{default: 0};
  int fall_cyc [2] = '{default: 0};
  int frames [2] = '{default: 0};

  // Mode-1 slave model and output monitor.
  always @(negedge clk) begin
    int d;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 2 : 1;
      if (rxv[k]) begin
        check("rx_single_pulse", rxv_p[k], 0);
        check("rx_with_cs_rise", {cs_p[k], cs_w[k]}, 2'b01);
        if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
        else check("rx_data", rxd[k], rx_q.pop_front());
      end
      if (cs_p[k] && !cs_w[k]) begin
        if (frames[k] > 0) check("cs_gap_min", cs_hi[k] >= d, 1);
        frames[k]++;
        cs_lo[k] = 0;
        tog[k] = 0;
        fall_cyc[k] = cyc;
        slv_tx[k] = (pre_q.size() > 0) ? pre_q.pop_front() : 8'h00;
      end
      if (!cs_p[k] && cs_w[k]) begin
        cs_hi[k] = 0;
        if (abort) begin
          abort = 1'b0;
          if (sl_q.size() > 0) void'(sl_q.pop_front());
        end else if (sl_q.size() == 0) begin
          check("slave_frame_unexpected", 1, 0);
        end else begin
          e = sl_q.pop_front();
          check("slave_data_out", slv_rx[k], e);
          check("mosi_at_rises", slv_rise[k], e);
          check("cs_low_cycles", cs_lo[k], 18 * d);
          check("sclk_edges", tog[k], 16);
          check("first_rise_delay", first_tog[k] - fall_cyc[k], d);
          check("sclk_span", last_tog[k] - first_tog[k], 15 * d);
        end
      end
      if (!cs_w[k]) begin
        cs_lo[k]++;
        if (sclk_w[k] != sclk_p[k]) begin
          tog[k]++;
          if (tog[k] == 1) first_tog[k] = cyc;
          last_tog[k] = cyc;
          if (sclk_w[k]) begin
            miso_s[k] = slv_tx[k][7];
            slv_tx[k] = {slv_tx[k][6:0], 1'b0};
            slv_rise[k] = {slv_rise[k][6:0], mosi_w[k]};
          end else begin
            slv_rx[k] = {slv_rx[k][6:0], mosi_w[k]};
          end
        end
      end else begin
        cs_hi[k]++;
      end
      sclk_p[k] = sclk_w[k];
      cs_p[k] = cs_w[k];
      rxv_p[k] = rxv[k];
    end
  end

  int last_acc = 0;

  task automatic send(input int k, input logic [7:0] d, input logic [7:0] pre,
                      input logic [7:0] exp_rx, input bit push_rx);
    int n;
    bit acc;
    n = 0;
    pre_q.push_back(pre);
    sl_q.push_back(d);
    if (push_rx) rx_q.push_back(exp_rx);
    txv[k] = 1'b1;
    txd[k] = d;
    forever begin
      acc = rdy[k];
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    txv[k] = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(rdy[k] && !bsy[k]) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", rdy[k] && !bsy[k], 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, r, n;
    logic prev;
    int exp_frames0;
    exp_frames0 = 4;
    txd[0] = 8'h00;
    txd[1] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_sclk", sclk_w[0], 0);
    check("rst_cs", cs_w[0], 1);
    check("rst_mosi", mosi_w[0], 0);
    check("rst_rx_valid", rxv[0], 0);
    check("rst_rx_data", rxd[0], 8'h00);
    check("rst_busy", bsy[0], 0);
    check("rst_tx_ready", rdy[0], 1);
    check("rst_cs_div1", cs_w[1], 1);

    // A5 against slave 3C, with a request pulsed mid-frame that must be ignored
    send(0, 8'hA5, 8'h3C, 8'h3C, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid_frame", bsy[0], 1);
    check("ready_low_mid_frame", rdy[0], 0);
    txv[0] = 1'b1;
    txd[0] = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    txv[0] = 1'b0;
    wait_idle(0);
    repeat (40) @(posedge clk);
    #1;
    check("frames_after_ignored_req", frames[0], 1);

    // back-to-back with tx_valid held high
    send(0, 8'h01, 8'h5A, 8'h5A, 1'b1);
    t0 = last_acc;
    send(0, 8'hFF, 8'h96, 8'h96, 1'b1);
    check("b2b_accept_spacing", last_acc - t0, 19 * 2 + 1);
    wait_idle(0);
    check("frames_b2b", frames[0], 3);

    // reset on the 4th sclk rise
    send(0, 8'hF0, 8'h0F, 8'h00, 1'b0);
    r = 0;
    n = 0;
    prev = sclk_w[0];
    while (r < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (sclk_w[0] && !prev) r++;
      prev = sclk_w[0];
    end
    check("fourth_rise_seen", r, 4);
    check("mosi_bit4_before_reset", mosi_w[0], 1);
    abort = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", cs_w[0], 1);
    check("midrst_sclk", sclk_w[0], 0);
    check("midrst_mosi", mosi_w[0], 0);
    check("midrst_rx_data", rxd[0], 8'h00);
    check("midrst_busy", bsy[0], 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("ready_after_midrst", rdy[0], 1);
    check("rx_data_still_zero", rxd[0], 8'h00);

    // CLK_DIV=1: 00 against slave FF
    send(1, 8'h00, 8'hFF, 8'hFF, 1'b1);
    wait_idle(1);
    check("frames_div1", frames[1], 1);

`ifdef SPI_MASTER_LOOPBACK_EN
    lb[0] = 1'b1;
    tie0 = 1'b1;
    send(0, 8'hC3, 8'hFF, 8'hC3, 1'b1);
    wait_idle(0);
    lb[0] = 1'b0;
    tie0 = 1'b0;
    exp_frames0 = 5;
`endif

    check("frames_dut0", frames[0], exp_frames0);
    check("rx_queue_drained", rx_q.size(), 0);
    check("slave_queue_drained", sl_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

endmodule
